ahb_dma_read_master: RTL

AHB_DMA_READ_MASTER -- requirements
Module: ahb_dma_read_master

---
 rtl/ahb3lite_pkg.sv | 28 ++
 rtl/ahb_dma_read_master.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_pkg.sv
// AHB-Lite transfer encodings and the state type shared by the DMA read master.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_INCR     = 3'b001;
  localparam logic [3:0] HPROT_PRIV_DATA = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_BURST = 3'd2,
    ST_LAST  = 3'd3,
    ST_ERR   = 3'd4
  } dma_state_e;

  // A beat that lands on a 1 KB boundary has to restart the burst.
  function automatic htrans_e seq_or_nonseq(input logic [9:0] addr_lo);
    return (addr_lo == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
  endfunction

endpackage

// File: rtl/ahb_dma_read_master.sv
// AHB-Lite DMA read master: fetches RCC_BUFFER_LENGTH words as an INCR burst
// and streams each returned word out on rd_data/rd_valid.
module ahb_dma_read_master
  import ahb3lite_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        NewCommandOn,
  input  logic [15:0] RCC_DMA_ADDR_HIGH,
  input  logic [15:0] RCC_DMA_ADDR_LOW,
  input  logic [5:0]  RCC_BUFFER_LENGTH,
  output logic        Master_Done,
  output logic        Master_Error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output dma_state_e  dbg_state
);

  // Handshake: an address phase is accepted, and the data phase in flight
  // completes, on any cycle with HREADY=1. HRESP=1 with HREADY=0 opens a
  // two-cycle error response that ends on the following HREADY=1 cycle.

  dma_state_e  state_q, state_d, adv_state;
  htrans_e     htrans_q, htrans_d, adv_trans;
  logic [31:0] haddr_q, haddr_d, adv_addr, next_addr;
  logic [31:0] rd_data_q, rd_data_d;
  logic [5:0]  beats_q, beats_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        nc_prev_q, nc_prev_d;
  logic        capture;

  assign capture   = NewCommandOn & ~nc_prev_q;
  assign nc_prev_d = NewCommandOn;
  assign next_addr = haddr_q + 32'd4;

  // beats_q counts beats whose address phase has not yet been accepted.
  always_comb begin
    if (beats_q > 6'd1) begin
      adv_state = ST_BURST;
      adv_trans = seq_or_nonseq(next_addr[9:0]);
      adv_addr  = next_addr;
    end else begin
      adv_state = ST_LAST;
      adv_trans = HTRANS_IDLE;
      adv_addr  = haddr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    htrans_d   = htrans_q;
    haddr_d    = haddr_q;
    beats_d    = beats_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          if (RCC_BUFFER_LENGTH == 6'd0) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = {RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW} & ~32'd3;
            beats_d  = RCC_BUFFER_LENGTH;
          end
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d  = adv_state;
          htrans_d = adv_trans;
          haddr_d  = adv_addr;
          beats_d  = beats_q - 6'd1;
        end
      end
      ST_BURST, ST_LAST: begin
        if (HRESP) begin
          htrans_d = HTRANS_IDLE;
          if (HREADY) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end else if (HREADY) begin
          rd_valid_d = 1'b1;
          rd_data_d  = HRDATA;
          if (state_q == ST_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = adv_state;
            htrans_d = adv_trans;
            haddr_d  = adv_addr;
            beats_d  = beats_q - 6'd1;
          end
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= '0;
      beats_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      nc_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      beats_q    <= beats_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      error_q    <= error_d;
      nc_prev_q  <= nc_prev_d;
    end
  end

  assign HADDR        = haddr_q;
  assign HTRANS       = htrans_q;
  assign HWRITE       = 1'b0;
  assign HSIZE        = HSIZE_WORD;
  assign HBURST       = HBURST_INCR;
  assign HPROT        = HPROT_PRIV_DATA;
  assign HWDATA       = 32'd0;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign Master_Done  = done_q;
  assign Master_Error = error_q;
  assign dbg_state    = state_q;

endmodule
